// File: rtl/sd_cmd_wb_master.sv
// Wishbone initiator that issues one SD command frame (with CRC7) to the SD FIFO
// controller's byte-wide register map, then collects and streams the response bytes.
module sd_cmd_wb_master #(
    parameter int unsigned TO_W           = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4095,
    parameter logic [2:0]  ADR_TXCMD      = 3'd0,
    parameter logic [2:0]  ADR_RXCMD      = 3'd1,
    parameter logic [2:0]  ADR_STATUS     = 3'd4
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [5:0]      req_cmd_i,
    input  logic [31:0]     req_arg_i,
    input  logic [1:0]      req_rsp_i,
    output logic [7:0]      rsp_byte_o,
    output logic            rsp_byte_vld_o,
    output logic            done_o,
    output logic            timeout_o,
    output logic [2:0]      m_wb_adr_o,
    output logic [7:0]      m_wb_dat_o,
    input  logic [7:0]      m_wb_dat_i,
    output logic [3:0]      m_wb_sel_o,
    output logic            m_wb_we_o,
    output logic            m_wb_cyc_o,
    output logic            m_wb_stb_o,
    input  logic            m_wb_ack_i
);

    localparam int unsigned FRAME_W = 40;
    localparam int unsigned CNT_W   = 6;
    localparam int unsigned RX_W    = 5;

    typedef enum logic [2:0] {
        S_IDLE, S_TX_POLL, S_TX_WRITE, S_RX_POLL, S_RX_READ, S_DONE, S_TMO
    } state_t;

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   frame_q;
    logic [FRAME_W-1:0]   crc_sh_q;
    logic [6:0]           crc_q;
    logic [CNT_W-1:0]     crc_cnt_q;
    logic [2:0]           byte_idx_q;
    logic [RX_W-1:0]      rx_cnt_q;
    logic [RX_W-1:0]      rx_len_q;
    logic [TO_W-1:0]      timer_q;

    logic                 accept_c, ack_c, crc_done_c, last_rx_c, last_tx_c, crc_fb_c;
    logic                 start_c, we_c;
    logic [2:0]           adr_c;
    logic [7:0]           dat_c, tx_byte_c;
    logic [6:0]           crc_next_c;
    logic [RX_W-1:0]      rx_len_c;

    assign m_wb_sel_o = 4'b0001;
    assign accept_c   = req_valid_i && req_ready_o && (state_q == S_IDLE);
    assign ack_c      = m_wb_cyc_o && m_wb_ack_i;
    assign crc_done_c = (crc_cnt_q == CNT_W'(FRAME_W));
    assign last_tx_c  = (byte_idx_q == 3'd5);
    assign last_rx_c  = ((rx_cnt_q + RX_W'(1)) == rx_len_q);
    assign crc_fb_c   = crc_sh_q[FRAME_W-1] ^ crc_q[6];
    assign crc_next_c = {crc_q[5:0], 1'b0} ^ (crc_fb_c ? 7'h09 : 7'h00);
    assign rx_len_c   = (req_rsp_i == 2'd0) ? RX_W'(0) :
                        (req_rsp_i == 2'd1) ? RX_W'(6) : RX_W'(17);

    // State register
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) state_q <= S_IDLE;
        else             state_q <= state_d;
    end

    // Next-state logic; transitions only at transfer completion or boundaries
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (accept_c) state_d = S_TX_POLL;
            S_TX_POLL:  if (ack_c && !m_wb_dat_i[0]) state_d = S_TX_WRITE;
            S_TX_WRITE: if (ack_c) begin
                            if (!last_tx_c)              state_d = S_TX_POLL;
                            else if (rx_len_q == '0)     state_d = S_DONE;
                            else                         state_d = S_RX_POLL;
                        end
            S_RX_POLL:  if (!m_wb_cyc_o && (timer_q == '0))  state_d = S_TMO;
                        else if (ack_c && !m_wb_dat_i[1])    state_d = S_RX_READ;
            S_RX_READ:  if (ack_c) state_d = last_rx_c ? S_DONE : S_RX_POLL;
            S_DONE:     state_d = S_IDLE;
            S_TMO:      state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Bus request decode; byte 5 waits for the serial CRC to finish
    always_comb begin
        start_c = 1'b0;
        adr_c   = ADR_STATUS;
        we_c    = 1'b0;
        dat_c   = 8'h00;
        case (byte_idx_q)
            3'd0:    tx_byte_c = frame_q[39:32];
            3'd1:    tx_byte_c = frame_q[31:24];
            3'd2:    tx_byte_c = frame_q[23:16];
            3'd3:    tx_byte_c = frame_q[15:8];
            3'd4:    tx_byte_c = frame_q[7:0];
            default: tx_byte_c = {crc_q, 1'b1};
        endcase
        if (!m_wb_cyc_o) begin
            case (state_q)
                S_TX_POLL:  start_c = 1'b1;
                S_TX_WRITE: begin
                    start_c = !last_tx_c || crc_done_c;
                    adr_c   = ADR_TXCMD;
                    we_c    = 1'b1;
                    dat_c   = tx_byte_c;
                end
                S_RX_POLL:  start_c = (timer_q != '0);
                S_RX_READ:  begin
                    start_c = 1'b1;
                    adr_c   = ADR_RXCMD;
                end
                default:    start_c = 1'b0;
            endcase
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            m_wb_cyc_o     <= 1'b0;
            m_wb_stb_o     <= 1'b0;
            m_wb_we_o      <= 1'b0;
            m_wb_adr_o     <= 3'd0;
            m_wb_dat_o     <= 8'h00;
            frame_q        <= '0;
            crc_sh_q       <= '0;
            crc_q          <= 7'h00;
            crc_cnt_q      <= '0;
            byte_idx_q     <= 3'd0;
            rx_cnt_q       <= '0;
            rx_len_q       <= '0;
            timer_q        <= '0;
            rsp_byte_o     <= 8'h00;
            rsp_byte_vld_o <= 1'b0;
            done_o         <= 1'b0;
            timeout_o      <= 1'b0;
            req_ready_o    <= 1'b0;
        end else begin
            if (start_c) begin
                m_wb_cyc_o <= 1'b1;
                m_wb_stb_o <= 1'b1;
                m_wb_we_o  <= we_c;
                m_wb_adr_o <= adr_c;
                m_wb_dat_o <= dat_c;
            end else if (ack_c) begin
                m_wb_cyc_o <= 1'b0;
                m_wb_stb_o <= 1'b0;
            end

            if (accept_c) begin
                frame_q    <= {2'b01, req_cmd_i, req_arg_i};
                crc_sh_q   <= {2'b01, req_cmd_i, req_arg_i};
                crc_q      <= 7'h00;
                crc_cnt_q  <= '0;
                byte_idx_q <= 3'd0;
                rx_cnt_q   <= '0;
                rx_len_q   <= rx_len_c;
            end else if (((state_q == S_TX_POLL) || (state_q == S_TX_WRITE)) && !crc_done_c) begin
                crc_q     <= crc_next_c;
                crc_sh_q  <= {crc_sh_q[FRAME_W-2:0], 1'b0};
                crc_cnt_q <= crc_cnt_q + CNT_W'(1);
            end

            if ((state_q == S_TX_WRITE) && ack_c) byte_idx_q <= byte_idx_q + 3'd1;

            rsp_byte_vld_o <= 1'b0;
            if ((state_q == S_RX_READ) && ack_c) begin
                rsp_byte_o     <= m_wb_dat_i;
                rsp_byte_vld_o <= 1'b1;
                rx_cnt_q       <= rx_cnt_q + RX_W'(1);
            end

            // Response timer: reload on entry and per byte, otherwise saturating countdown
            if (((state_q == S_TX_WRITE) && ack_c && last_tx_c) ||
                ((state_q == S_RX_READ) && ack_c)) begin
                timer_q <= TO_W'(TIMEOUT_CYCLES);
            end else if (((state_q == S_RX_POLL) || (state_q == S_RX_READ)) && (timer_q != '0)) begin
                timer_q <= timer_q - TO_W'(1);
            end

            done_o      <= (state_d == S_DONE) || (state_d == S_TMO);
            timeout_o   <= (state_d == S_TMO);
            req_ready_o <= (state_d == S_IDLE);
        end
    end

endmodule

// File: tb/tb_sd_cmd_wb_master.sv
// Scoreboard bench for sd_cmd_wb_master: behavioural FIFO-controller slave, bus
// protocol checker, and an event monitor comparing writes/response bytes/done.
module tb_sd_cmd_wb_master;

    localparam int unsigned TMO = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_cmd = 6'd0;
    logic [31:0] req_arg = 32'd0;
    logic [1:0]  req_rsp = 2'd0;
    logic [7:0]  rsp_byte;
    logic        rsp_vld, done, tmo;
    logic [2:0]  adr;
    logic [7:0]  wdat;
    logic [7:0]  rdat = 8'h00;
    logic [3:0]  sel;
    logic        we, cyc, stb;
    logic        ack = 1'b0;

    sd_cmd_wb_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_cmd_i(req_cmd), .req_arg_i(req_arg), .req_rsp_i(req_rsp),
        .rsp_byte_o(rsp_byte), .rsp_byte_vld_o(rsp_vld),
        .done_o(done), .timeout_o(tmo),
        .m_wb_adr_o(adr), .m_wb_dat_o(wdat), .m_wb_dat_i(rdat), .m_wb_sel_o(sel),
        .m_wb_we_o(we), .m_wb_cyc_o(cyc), .m_wb_stb_o(stb), .m_wb_ack_i(ack)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [1:0] kind; logic [7:0] val; } exp_t;
    localparam logic [1:0] K_WR = 2'd0, K_RSP = 2'd1, K_DONE = 2'd2;

    exp_t        exp_q[$];
    int          vectors = 0, miscompares = 0;
    int          n_status = 0, n_rxrd = 0, n_wr = 0, n_done = 0;
    longint      cyc_n = 0, last_wr_t = 0, done_t = 0;
    logic        chk_en = 1'b0;

    // slave configuration / state
    int          lat = 2, wcnt = 0, wr_seen = 0, full_at = -1, full_left = 0;
    int          rx_delay = 0, dly = 0;
    logic [7:0]  rx_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input string name, input logic [1:0] kind, input logic [7:0] val);
        exp_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got unexpected kind %0d value %0h, expected nothing", name, kind, val);
        end else begin
            e = exp_q.pop_front();
            check(name, 32'({kind, val}), 32'({e.kind, e.val}));
        end
    endtask

    // Behavioural slave: acks after `lat` cycles, models TX-full and RX-empty status
    initial forever begin
        logic full;
        @(negedge clk);
        if (rx_delay > 0) rx_delay--;
        if (!rst_n || !(cyc && stb)) begin
            ack = 1'b0;
            wcnt = 0;
        end else if (ack) begin
            ack = 1'b0;
        end else if (wcnt + 1 >= lat) begin
            ack = 1'b1;
            wcnt = 0;
            if (we) begin
                wr_seen++;
                rx_delay = dly;
            end else if (adr == 3'd4) begin
                full = (wr_seen == full_at) && (full_left > 0);
                if (full) full_left--;
                rdat = {6'b0, (rx_q.size() == 0) || (rx_delay > 0), full};
            end else begin
                rdat = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hEE;
                rx_delay = dly;
            end
        end else begin
            wcnt++;
        end
    end

    // Bus checker and output monitor, sampled 1 time unit after the clock edge
    initial begin
        logic p_cyc = 1'b0, p_stb = 1'b0, p_we = 1'b0, p_done = 1'b0;
        logic [2:0] p_adr = 3'd0;
        logic [7:0] p_dat = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            cyc_n++;
            if (!rst_n || !chk_en) begin
                p_cyc = 1'b0; p_stb = 1'b0; p_done = 1'b0;
            end else begin
                if (stb && !cyc) check("stb_without_cyc", 32'(stb), 32'd0);
                if (p_stb) begin
                    if (ack) begin
                        check("gap_after_ack", 32'({cyc, stb}), 32'd0);
                        if (p_we) begin
                            check("write_adr", 32'(p_adr), 32'd0);
                            n_wr++;
                            last_wr_t = cyc_n;
                            sb_pop("tx_byte", K_WR, p_dat);
                        end else if (p_adr == 3'd4) n_status++;
                        else if (p_adr == 3'd1) n_rxrd++;
                        else check("read_adr", 32'(p_adr), 32'd4);
                    end else begin
                        check("hold_until_ack", 32'({cyc, stb, we, adr, wdat}),
                              32'({p_cyc, p_stb, p_we, p_adr, p_dat}));
                    end
                end
                if (rsp_vld) sb_pop("rsp_byte", K_RSP, rsp_byte);
                if (done) begin
                    n_done++;
                    done_t = cyc_n;
                    sb_pop("done_timeout", K_DONE, {7'd0, tmo});
                    check("ready_during_done", 32'(req_ready), 32'd0);
                end
                if (p_done) check("ready_after_done", 32'(req_ready), 32'd1);
                p_cyc = cyc; p_stb = stb; p_we = we; p_adr = adr; p_dat = wdat; p_done = done;
            end
        end
    end

    task automatic push_frame(input logic [47:0] f);
        for (int i = 5; i >= 0; i--) exp_q.push_back('{K_WR, f[i*8 +: 8]});
    endtask

    task automatic new_test(input int l, input int d);
        n_status = 0; n_rxrd = 0; n_wr = 0;
        wr_seen = 0; full_at = -1; full_left = 0; rx_delay = 0;
        lat = l; dly = d;
        rx_q.delete();
    endtask

    task automatic send(input logic [5:0] c, input logic [31:0] a, input logic [1:0] r);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_cmd = c; req_arg = a; req_rsp = r;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("req_accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (n_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_count", 32'(n_done), 32'(target));
        repeat (3) @(negedge clk);
    endtask

    task automatic end_checks(input int st, input int rx, input int wr);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("status_reads", 32'(n_status), 32'(st));
        check("rx_reads", 32'(n_rxrd), 32'(rx));
        check("tx_writes", 32'(n_wr), 32'(wr));
        check("ready_idle", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [47:0] f_cmd0  = 48'h40_00_00_00_00_95;
        logic [47:0] f_cmd8  = 48'h48_00_00_01_AA_87;
        logic [47:0] f_acmd41 = 48'h69_40_00_00_00_77;
        logic [47:0] f_cmd55 = 48'h77_00_00_00_00_65;
        logic [47:0] r8 = 48'h08_00_00_01_AA_13;
        longint dt;
        int n, done_snap;

        // reset values
        repeat (3) @(negedge clk);
        check("reset_outputs",
              32'({req_ready, rsp_byte, rsp_vld, done, tmo, adr, wdat, sel, we, cyc, stb}),
              32'({1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 4'b0001, 3'b000}));
        rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'd1);

        // CMD0, no response
        new_test(2, 0);
        push_frame(f_cmd0);
        exp_q.push_back('{K_DONE, 8'h00});
        send(6'd0, 32'h0, 2'd0);
        wait_done(1, 2000);
        end_checks(6, 0, 6);

        // CMD8, short response, single-cycle ack (CRC stall on byte 5)
        new_test(1, 0);
        for (int i = 5; i >= 0; i--) begin
            rx_q.push_back(r8[i*8 +: 8]);
            exp_q.push_back('{K_RSP, r8[i*8 +: 8]});
        end
        exp_q = {exp_q, exp_t'(0)};
        void'(exp_q.pop_back());
        begin
            exp_t tmp[$];
            tmp = exp_q;
            exp_q.delete();
            push_frame(f_cmd8);
            exp_q = {exp_q, tmp};
        end
        exp_q.push_back('{K_DONE, 8'h00});
        send(6'd8, 32'h0000_01AA, 2'd1);
        wait_done(2, 2000);
        end_checks(12, 6, 6);

        // CMD8 with TX FIFO full for 5 polls before byte 2
        new_test(3, 0);
        full_at = 2; full_left = 5;
        push_frame(f_cmd8);
        for (int i = 5; i >= 0; i--) begin
            rx_q.push_back(r8[i*8 +: 8]);
            exp_q.push_back('{K_RSP, r8[i*8 +: 8]});
        end
        exp_q.push_back('{K_DONE, 8'h00});
        send(6'd8, 32'h0000_01AA, 2'd1);
        wait_done(3, 3000);
        end_checks(17, 6, 6);

        // ACMD41 with the RX FIFO never filling: timeout
        new_test(2, 0);
        push_frame(f_acmd41);
        exp_q.push_back('{K_DONE, 8'h01});
        send(6'd41, 32'h4000_0000, 2'd1);
        wait_done(4, 3000);
        end_checks(n_status, 0, 6);
        dt = done_t - last_wr_t;
        check("timeout_window", 32'((dt >= longint'(TMO) - 8) && (dt <= longint'(TMO) + 8)), 32'd1);

        // CMD55, long response, each byte delayed close to the timeout
        new_test(2, TMO - 20);
        push_frame(f_cmd55);
        for (int i = 0; i < 17; i++) begin
            logic [7:0] b;
            b = (i == 0) ? 8'h3F : 8'(8'h10 + i);
            rx_q.push_back(b);
            exp_q.push_back('{K_RSP, b});
        end
        exp_q.push_back('{K_DONE, 8'h00});
        send(6'd55, 32'h0, 2'd2);
        wait_done(5, 10000);
        end_checks(n_status, 17, 6);

        // Reset asserted during byte 3's strobe
        new_test(8, 0);
        for (int i = 5; i >= 3; i--) exp_q.push_back('{K_WR, f_cmd8[i*8 +: 8]});
        done_snap = n_done;
        send(6'd8, 32'h0000_01AA, 2'd1);
        n = 0;
        while (!(n_wr == 3 && stb && we) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("byte3_strobe_seen", 32'(stb && we), 32'd1);
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("reset_drops_cyc_stb", 32'({cyc, stb}), 32'd0);
        check("partial_frame", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("ready_after_midreset", 32'(req_ready), 32'd1);
        check("no_done_on_reset", 32'(n_done), 32'(done_snap));
        chk_en = 1'b1;

        // Fresh CMD0 after reset
        new_test(2, 0);
        push_frame(f_cmd0);
        exp_q.push_back('{K_DONE, 8'h00});
        send(6'd0, 32'h0, 2'd0);
        wait_done(done_snap + 1, 2000);
        end_checks(6, 0, 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
